udc_bus_master: RTL and testbench

//  Bus initiator for the up/down counter register port. Converts single-word

---
 rtl/udc_bus_master_if.sv | 28 ++
 rtl/udc_bus_master.sv | 159 +++++++++++++++
 tb/tb_udc_bus_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udc_bus_master_if.sv
// Command/response port of the up/down counter bus initiator.
//   master : the controller side, issues commands and takes responses
//   slave  : udc_bus_master itself, accepts commands and reports results
// Signals:
//   cmd_valid/cmd_ready  command handshake, transfer when both high
//   cmd_op               00 WRITE, 01 READ, 10 START, 11 WAIT_EC
//   cmd_addr             register {A1,A0}
//   cmd_wdata            write data
//   rsp_valid/rsp_data   one-cycle result pulse, no back-pressure
interface udc_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/udc_bus_master.sv
// Bus initiator for the up/down counter register port. Turns single-word
// commands (write, read, start, wait-for-end-cycle) into ncs/nwr/nrd/A1:A0/Din
// cycles and start strobes, and returns read data or status.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   cmd             command/response interface (slave side)
//   ncs, nwr, nrd   active-low chip select / write / read strobes
//   a1, a0          register address
//   start           counter start pulse
//   Din             bidirectional data bus, driven only during a write
//   ec_in, err_in   counter end-cycle and limit-error flags
module udc_bus_master #(
    parameter int WR_PULSE   = 2,
    parameter int RD_WAIT    = 2,
    parameter int START_LEN  = 1,
    parameter int EC_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    udc_bus_master_if.slave  cmd,
    output logic             ncs,
    output logic             nwr,
    output logic             nrd,
    output logic             a0,
    output logic             a1,
    output logic             start,
    inout  wire  [7:0]       Din,
    input  logic             ec_in,
    input  logic             err_in
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;

    // Out-of-range start lengths fall back to a single-cycle pulse.
    localparam int START_CYC = (START_LEN == 1 || START_LEN == 2) ? START_LEN : 1;

    // Per-state cycle counter terminal values (counter starts at 0 in each state).
    localparam logic [9:0] WR_LAST = 10'(WR_PULSE - 1);
    localparam logic [9:0] RD_LAST = 10'(RD_WAIT - 1);
    localparam logic [9:0] ST_LAST = 10'(START_CYC - 1);
    localparam logic [9:0] EC_LAST = 10'(EC_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RSTROBE, STRT, WAITEC, RESP
    } state_t;

    state_t     state, state_nx;
    logic [9:0] cnt_q, cnt_nx;
    logic [7:0] rsp_q, rsp_nx;
    logic [7:0] wdata_q;
    logic [1:0] addr_q;
    logic       sel_q;      // set by the first accepted command, cleared only by reset
    logic       nwr_q, nrd_q, start_q, din_oe_q;
    logic       accept;

    // Next-state and response capture.
    always_comb begin
        state_nx = state;
        rsp_nx   = rsp_q;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    accept = 1'b1;
                    unique case (cmd.cmd_op)
                        OP_WRITE: state_nx = WSETUP;
                        OP_READ:  state_nx = RSETUP;
                        OP_START: begin
                            // A latched limit error suppresses the pulse entirely.
                            if (err_in) begin
                                state_nx = RESP;
                                rsp_nx   = 8'h01;
                            end else begin
                                state_nx = STRT;
                            end
                        end
                        default:  state_nx = WAITEC;
                    endcase
                end
            end
            WSETUP:  state_nx = WSTROBE;
            WSTROBE: if (cnt_q == WR_LAST) state_nx = WHOLD;
            WHOLD:   state_nx = IDLE;
            RSETUP:  state_nx = RSTROBE;
            RSTROBE: begin
                if (cnt_q == RD_LAST) begin
                    state_nx = RESP;
                    rsp_nx   = Din;
                end
            end
            STRT: begin
                if (cnt_q == ST_LAST) begin
                    state_nx = RESP;
                    rsp_nx   = 8'h00;
                end
            end
            WAITEC: begin
                // ec_in takes priority over an expiring timer in the same cycle.
                if (ec_in) begin
                    state_nx = RESP;
                    rsp_nx   = {6'b0, 1'b0, err_in};
                end else if (cnt_q == EC_LAST) begin
                    state_nx = RESP;
                    rsp_nx   = {6'b0, 1'b1, err_in};
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (state_nx != state || state == IDLE) cnt_nx = '0;
        else                                    cnt_nx = cnt_q + 10'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt_q    <= '0;
            rsp_q    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            sel_q    <= 1'b0;
            nwr_q    <= 1'b1;
            nrd_q    <= 1'b1;
            start_q  <= 1'b0;
            din_oe_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt_q <= cnt_nx;
            rsp_q <= rsp_nx;
            if (accept) begin
                sel_q   <= 1'b1;
                wdata_q <= cmd.cmd_wdata;
                // START/WAIT_EC leave the last bus address in place.
                if (!cmd.cmd_op[1]) addr_q <= cmd.cmd_addr;
            end
            // Strobes come straight off flops so the counter never sees decode glitches.
            nwr_q    <= (state_nx != WSTROBE);
            nrd_q    <= (state_nx != RSTROBE);
            start_q  <= (state_nx == STRT);
            din_oe_q <= (state_nx == WSETUP) || (state_nx == WSTROBE) || (state_nx == WHOLD);
        end
    end

    assign ncs   = ~sel_q;
    assign nwr   = nwr_q;
    assign nrd   = nrd_q;
    assign start = start_q;
    assign a1    = addr_q[1];
    assign a0    = addr_q[0];
    assign Din   = din_oe_q ? wdata_q : 8'bz;

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.rsp_valid = (state == RESP);
    assign cmd.rsp_data  = rsp_q;

endmodule

// File: tb/tb_udc_bus_master.sv
// Bench for udc_bus_master: a small counter register device on the bus, a
// transaction-level model checked every cycle, and directed command vectors
// with hand-computed results.
module tb_udc_bus_master;

    localparam int WR_PULSE   = 2;
    localparam int RD_WAIT    = 2;
    localparam int START_LEN  = 1;
    localparam int EC_TIMEOUT = 1023;
    localparam int ST_CYC     = 1;

    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_ST = 2'b10;
    localparam logic [1:0] OP_WE = 2'b11;

    logic clk = 1'b0;
    logic reset;
    logic ncs, nwr, nrd, a0, a1, start, ec_in, err_in;
    wire  [7:0] Din;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    udc_bus_master_if bus();

    udc_bus_master #(
        .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT),
        .START_LEN(START_LEN), .EC_TIMEOUT(EC_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .cmd(bus),
        .ncs(ncs), .nwr(nwr), .nrd(nrd), .a0(a0), .a1(a1), .start(start),
        .Din(Din), .ec_in(ec_in), .err_in(err_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter register device: latches Din while nwr is low, returns registers on nrd.
    logic [7:0] dev_regs [4];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) dev_regs[i] <= 8'h00;
        end else if (!ncs && !nwr) begin
            dev_regs[{a1, a0}] <= Din;
        end
    end
    assign Din    = (!ncs && !nrd) ? dev_regs[{a1, a0}] : 8'bz;
    assign err_in = dev_regs[0] > dev_regs[1];   // PLR above ULR is a limit error

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: each command is a fixed timeline of cycles after acceptance
    // (WAIT_EC length decided by ec_in / timer), plus a register image built from
    // the write commands issued.
    logic [1:0] m_op, m_addr;
    logic [7:0] m_wd, m_rsp;
    logic [7:0] mregs [4];
    bit         m_busy, m_ever, m_err, m_resp;
    int         m_k;

    initial begin
        logic e_nwr, e_nrd, e_start, e_rv;
        logic [7:0] e_data;
        m_busy = 0; m_ever = 0; m_resp = 0; m_k = 0; m_err = 0;
        m_op = 0; m_addr = 0; m_wd = 0; m_rsp = 0;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_ncs", ncs, 1);
                chk("rst_nwr", nwr, 1);
                chk("rst_nrd", nrd, 1);
                chk("rst_start", start, 0);
                chk("rst_addr", {a1, a0}, 0);
                chk("rst_ready", bus.cmd_ready, 1);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_rsp_data", bus.rsp_data, 0);
                m_busy = 0; m_ever = 0;
                for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
            end else begin
                e_nwr = 1; e_nrd = 1; e_start = 0; e_rv = 0; e_data = 8'h00;
                if (m_busy) begin
                    case (m_op)
                        OP_WR: begin
                            if (m_k >= 2 && m_k <= WR_PULSE + 1) e_nwr = 0;
                            chk("din_wdata", Din, m_wd);
                        end
                        OP_RD: begin
                            if (m_k >= 2 && m_k <= RD_WAIT + 1) e_nrd = 0;
                            if (m_k == RD_WAIT + 2) begin e_rv = 1; e_data = mregs[m_addr]; end
                        end
                        OP_ST: begin
                            if (m_err)              begin e_rv = 1; e_data = 8'h01; end
                            else if (m_k <= ST_CYC) e_start = 1;
                            else                    begin e_rv = 1; e_data = 8'h00; end
                        end
                        default: if (m_resp) begin e_rv = 1; e_data = m_rsp; end
                    endcase
                    if (m_op == OP_WR || m_op == OP_RD) chk("addr", {a1, a0}, m_addr);
                end
                chk("cmd_ready", bus.cmd_ready, !m_busy);
                chk("ncs", ncs, !m_ever);
                chk("nwr", nwr, e_nwr);
                chk("nrd", nrd, e_nrd);
                chk("start", start, e_start);
                chk("rsp_valid", bus.rsp_valid, e_rv);
                if (e_rv) chk("rsp_data", bus.rsp_data, e_data);

                if (m_busy) begin
                    if (e_rv || (m_op == OP_WR && m_k == WR_PULSE + 2)) begin
                        m_busy = 0;
                        if (m_op == OP_WR) mregs[m_addr] = m_wd;
                    end else begin
                        if (m_op == OP_WE && (ec_in || m_k - 1 == EC_TIMEOUT)) begin
                            m_resp = 1;
                            m_rsp  = {6'b0, ~ec_in, err_in};
                        end
                        m_k++;
                    end
                end else if (bus.cmd_valid) begin
                    m_busy = 1; m_ever = 1; m_resp = 0; m_k = 1;
                    m_op = bus.cmd_op; m_addr = bus.cmd_addr; m_wd = bus.cmd_wdata;
                    m_err = err_in;
                end
            end
        end
    end

    // Present a command and hold it until accepted; fields are scrambled right
    // after acceptance to show they are not sampled again.
    task automatic issue(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] wd,
                         input bit keep, output int acc_cyc);
        bit done = 0;
        acc_cyc = -1;
        bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc_cyc = cyc;
                done = 1;
                @(posedge clk); #1;
                if (!keep) bus.cmd_valid = 1'b0;
                bus.cmd_op = ~op; bus.cmd_addr = ~addr; bus.cmd_wdata = ~wd;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_wait: command never accepted, expected acceptance");
        end
    endtask

    task automatic wait_rsp(input int acc_cyc, output logic [7:0] data, output int lat);
        bit done = 0;
        data = 8'hxx; lat = -1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                data = bus.rsp_data; lat = cyc - acc_cyc; done = 1;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_wait: no rsp_valid, expected a response");
        end
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [7:0] wd);
        int a;
        issue(OP_WR, addr, wd, 0, a);
        repeat (WR_PULSE + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        int a1c, a2c, lat;
        logic [7:0] d;
        reset = 1'b1; ec_in = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 2'b00; bus.cmd_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of the write strobe releases the bus immediately.
        issue(OP_WR, 2'd3, 8'h77, 0, a1c);
        @(posedge clk); #1;
        chk("midwr_nwr_low", nwr, 0);
        reset = 1'b1;
        #1;
        chk("midwr_ncs_rel", ncs, 1);
        chk("midwr_nwr_rel", nwr, 1);
        chk("midwr_ready", bus.cmd_ready, 1);
        @(negedge clk); @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back register writes: PLR=1, ULR=2, LLR=0, CCR=2.
        issue(OP_WR, 2'd0, 8'd1, 1, a1c);
        issue(OP_WR, 2'd1, 8'd2, 1, a2c);
        chk("b2b_gap", a2c - a1c, WR_PULSE + 3);
        issue(OP_WR, 2'd2, 8'd0, 1, a1c);
        issue(OP_WR, 2'd3, 8'd2, 0, a2c);
        chk("b2b_gap2", a2c - a1c, WR_PULSE + 3);
        repeat (WR_PULSE + 3) @(posedge clk);
        #1;

        // Read back ULR.
        issue(OP_RD, 2'd1, 8'h00, 0, a1c);
        wait_rsp(a1c, d, lat);
        chk("read_ulr_data", d, 8'h02);
        chk("read_lat", lat, RD_WAIT + 2);

        // START with no error: single-cycle pulse, status 0.
        issue(OP_ST, 2'd0, 8'h00, 0, a1c);
        wait_rsp(a1c, d, lat);
        chk("start_data", d, 8'h00);
        chk("start_lat", lat, ST_CYC + 1);

        // WAIT_EC, end-cycle arrives a few cycles in.
        issue(OP_WE, 2'd0, 8'h00, 0, a1c);
        repeat (5) @(posedge clk);
        #1 ec_in = 1'b1;
        wait_rsp(a1c, d, lat);
        chk("waitec_data", d, 8'h00);
        #1 ec_in = 1'b0;

        // WAIT_EC with end-cycle already high on entry.
        ec_in = 1'b1;
        issue(OP_WE, 2'd0, 8'h00, 0, a1c);
        wait_rsp(a1c, d, lat);
        chk("waitec_entry_lat", lat, 2);
        chk("waitec_entry_data", d, 8'h00);
        #1 ec_in = 1'b0;

        // PLR=5 above ULR: START is refused with the error bit.
        write_reg(2'd0, 8'd5);
        issue(OP_ST, 2'd0, 8'h00, 0, a1c);
        wait_rsp(a1c, d, lat);
        chk("start_err_data", d, 8'h01);
        chk("start_err_lat", lat, 1);

        // Back to PLR=1, then let WAIT_EC time out.
        write_reg(2'd0, 8'd1);
        issue(OP_WE, 2'd0, 8'h00, 0, a1c);
        wait_rsp(a1c, d, lat);
        chk("timeout_data", d, 8'h02);
        chk("timeout_lat", lat, EC_TIMEOUT + 2);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
